// File: rtl/prod_accum_pkg.sv
// Shared types, default sizes and the product extension helper for prod_accum.
// Optional build macro PROD_ACCUM_SAT_EN is consumed only by prod_accum_add.
package prod_accum_pkg;

  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;
  localparam int PROD_W    = 32;
  // Widest accumulator the extension helper can serve.
  localparam int EXT_MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Direction the accumulator is currently pinned in (saturating build only).
  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_t;

  // Sign- or zero-extend a product up to acc_w bits; bits above acc_w are zero.
  function automatic logic [EXT_MAX_W-1:0] ext(input logic [PROD_W-1:0] prod,
                                               input logic              signed_flag,
                                               input int                acc_w);
    logic [EXT_MAX_W-1:0] r;
    r = '0;
    r[PROD_W-1:0] = prod;
    for (int i = PROD_W; i < EXT_MAX_W; i++) begin
      if (i < acc_w) r[i] = signed_flag & prod[PROD_W-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/prod_accum_add.sv
// Combinational ACC_W-bit accumulator adder.
// With PROD_ACCUM_SAT_EN defined it detects signed overflow and clamps,
// keeping the clamp direction until an overflow of the opposite sign.
// Without it the add simply wraps and no overflow logic exists.
module prod_accum_add
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  sat_t             sat_in,
  output logic [ACC_W-1:0] sum,
  output logic             ovf,
  output sat_t             sat_out
);

  logic [ACC_W-1:0] raw;
  assign raw = a + b;

`ifdef PROD_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  logic pos_ovf;
  logic neg_ovf;

  // Overflow: both operands share a sign and the result sign differs.
  assign pos_ovf = ~a[ACC_W-1] & ~b[ACC_W-1] &  raw[ACC_W-1];
  assign neg_ovf =  a[ACC_W-1] &  b[ACC_W-1] & ~raw[ACC_W-1];
  assign ovf     = pos_ovf | neg_ovf;

  // Clamp on overflow; an earlier clamp pins the result until a reversing overflow.
  always_comb begin
    sum     = raw;
    sat_out = sat_in;
    if (pos_ovf) begin
      sum     = MAX_POS;
      sat_out = SAT_POS;
    end else if (neg_ovf) begin
      sum     = MIN_NEG;
      sat_out = SAT_NEG;
    end else if (sat_in == SAT_POS) begin
      sum = MAX_POS;
    end else if (sat_in == SAT_NEG) begin
      sum = MIN_NEG;
    end
  end
`else
  logic unused_sat;

  assign sum        = raw;
  assign ovf        = 1'b0;
  assign sat_out    = SAT_NONE;
  assign unused_sat = ^sat_in;
`endif

endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums a programmed number of 32-bit multiplier products into a
// wide two's-complement accumulator and hands each sum out on a valid/ready port.
// Product input has no back-pressure; products arriving outside ACC are dropped
// and flagged on o_drop. Saturation is enabled by defining PROD_ACCUM_SAT_EN.
// ACC_W must be at least 33 so a full unsigned product fits as a positive value.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [CNT_W-1:0]   i_len,
  input  logic               i_prod_vld,
  input  logic [PROD_W-1:0]  i_prod,
  input  logic               i_prod_signed,
  output logic               o_busy,
  output logic               o_acc_vld,
  input  logic               i_acc_rdy,
  output logic [ACC_W-1:0]   o_acc,
  output logic               o_ovf,
  output logic               o_drop
);

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  sat_t             sat_reg;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  sat_t             add_sat;
  logic             start_ok;

  assign prod_ext = ACC_W'(ext(i_prod, i_prod_signed, ACC_W));

  // A start is honoured from IDLE, or from DONE when the result leaves this cycle.
  assign start_ok = i_start &
                    ((state_reg == IDLE) | ((state_reg == DONE) & i_acc_rdy));

  prod_accum_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .a       (acc_reg),
    .b       (prod_ext),
    .sat_in  (sat_reg),
    .sum     (add_sum),
    .ovf     (add_ovf),
    .sat_out (add_sat)
  );

  // Control FSM with accumulator, counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      sat_reg   <= SAT_NONE;
      o_busy    <= 1'b0;
      o_acc_vld <= 1'b0;
      o_acc     <= '0;
      o_ovf     <= 1'b0;
      o_drop    <= 1'b0;
    end else begin
      o_drop <= i_prod_vld & (state_reg != ACC);
      case (state_reg)
        IDLE, DONE: begin
          if ((state_reg == DONE) && i_acc_rdy) begin
            state_reg <= IDLE;
            o_busy    <= 1'b0;
            o_acc_vld <= 1'b0;
          end
          if (start_ok) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
            sat_reg <= SAT_NONE;
            o_ovf   <= 1'b0;
            o_busy  <= 1'b1;
            if (i_len != '0) begin
              state_reg <= ACC;
              cnt_reg   <= i_len;
              o_acc_vld <= 1'b0;
            end else begin
              // Empty burst: publish a zero result straight away.
              state_reg <= DONE;
              o_acc     <= '0;
              o_acc_vld <= 1'b1;
            end
          end
        end
        ACC: begin
          if (i_prod_vld) begin
            acc_reg <= add_sum;
            cnt_reg <= cnt_reg - CNT_W'(1);
            ovf_reg <= ovf_reg | add_ovf;
            sat_reg <= add_sat;
            if (cnt_reg == CNT_W'(1)) begin
              state_reg <= DONE;
              o_acc_vld <= 1'b1;
              o_acc     <= add_sum;
              o_ovf     <= ovf_reg | add_ovf;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          o_busy    <= 1'b0;
          o_acc_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: stimulus pushes expected results, a monitor
// pops and compares on every result handshake. Directed vectors only.
module tb_prod_accum;

  localparam int ACC_W = 40;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             prod_vld;
  logic [31:0]      prod;
  logic             prod_signed;
  logic             busy;
  logic             acc_vld;
  logic             acc_rdy;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             drop;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  prod_accum #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_start       (start),
    .i_len         (len),
    .i_prod_vld    (prod_vld),
    .i_prod        (prod),
    .i_prod_signed (prod_signed),
    .o_busy        (busy),
    .o_acc_vld     (acc_vld),
    .i_acc_rdy     (acc_rdy),
    .o_acc         (acc),
    .o_ovf         (ovf),
    .o_drop        (drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] p, input logic s);
    prod_vld    = 1'b1;
    prod        = p;
    prod_signed = s;
    tick();
    prod_vld    = 1'b0;
  endtask

  task automatic expect_result(input logic [ACC_W-1:0] a, input logic o);
    exp_t e;
    e.acc = a;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // Monitor: every result handshake is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rstn && acc_vld && acc_rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got acc=%0h, required no result", acc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_acc", 64'(acc), 64'(e.acc));
        check("result_ovf", 64'(ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W-1:0] sat_acc;
    logic             sat_ovf;
`ifdef PROD_ACCUM_SAT_EN
    sat_acc = 40'h7FFFFFFFFF;
    sat_ovf = 1'b1;
`else
    sat_acc = 40'hFEFFFFFF01;
    sat_ovf = 1'b0;
`endif
    rstn = 1'b0; start = 1'b0; len = '0; prod_vld = 1'b0;
    prod = '0; prod_signed = 1'b0; acc_rdy = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_vld",  64'(acc_vld), 0);
    check("rst_acc",  64'(acc), 0);
    check("rst_ovf",  64'(ovf), 0);
    check("rst_drop", 64'(drop), 0);
    tick();
    rstn = 1'b1;
    tick();

    // Basic unsigned sum, latency exactly one cycle
    expect_result(40'h60, 1'b0);
    do_start(3);
    send(32'h10, 1'b0);
    send(32'h20, 1'b0);
    @(negedge clk);
    check("lat_vld_before", 64'(acc_vld), 0);
    send(32'h30, 1'b0);
    @(negedge clk);
    check("lat_vld_rise", 64'(acc_vld), 1);
    @(negedge clk);
    check("vld_one_cycle", 64'(acc_vld), 0);
    tick();

    // Signed -1 plus unsigned 0xFFFFFFFF
    expect_result(40'h00FFFFFFFE, 1'b0);
    do_start(2);
    send(32'hFFFFFFFF, 1'b1);
    send(32'hFFFFFFFF, 1'b0);
    tick();
    tick();

    // Back-pressure, then handshake with start in the same cycle
    acc_rdy = 1'b0;
    expect_result(40'h5, 1'b0);
    do_start(1);
    send(32'h5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_vld", 64'(acc_vld), 1);
      check("bp_acc", 64'(acc), 64'h5);
      tick();
    end
    acc_rdy = 1'b1;
    expect_result(40'h7, 1'b0);
    do_start(1);
    @(negedge clk);
    check("b2b_busy", 64'(busy), 1);
    check("b2b_vld",  64'(acc_vld), 0);
    send(32'h7, 1'b0);
    tick();
    tick();

    // Gaps in products plus an ignored start during ACC
    expect_result(40'h300, 1'b0);
    do_start(2);
    repeat (3) tick();
    send(32'h100, 1'b0);
    repeat (2) tick();
    do_start(1);
    @(negedge clk);
    check("ign_start_drop", 64'(drop), 0);
    send(32'h200, 1'b0);
    tick();

    // Product while IDLE is dropped and leaves the result alone
    send(32'h55, 1'b0);
    @(negedge clk);
    check("idle_drop", 64'(drop), 1);
    check("idle_acc_hold", 64'(acc), 64'h300);
    @(negedge clk);
    check("drop_one_cycle", 64'(drop), 0);
    tick();

    // Zero-length burst
    expect_result(40'h0, 1'b0);
    do_start(0);
    @(negedge clk);
    check("len0_vld", 64'(acc_vld), 1);
    tick();
    tick();

    // Reset in the middle of an accumulation
    do_start(3);
    send(32'h1, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_vld",  64'(acc_vld), 0);
    check("midrst_acc",  64'(acc), 0);
    check("midrst_ovf",  64'(ovf), 0);
    tick();
    rstn = 1'b1;
    send(32'h2, 1'b0);
    send(32'h3, 1'b0);
    repeat (4) tick();

    // Long signed burst staying inside range
    expect_result(40'h7F7FFFFF01, 1'b0);
    do_start(8'd255);
    for (int i = 0; i < 255; i++) send(32'h7FFFFFFF, 1'b1);
    tick();
    tick();

    // Long unsigned burst crossing the signed limit
    expect_result(sat_acc, sat_ovf);
    do_start(8'd255);
    for (int i = 0; i < 255; i++) send(32'hFFFFFFFF, 1'b0);
    tick();
    tick();

    // Next accumulation starts with a clean overflow flag
    expect_result(40'h1, 1'b0);
    do_start(1);
    send(32'h1, 1'b0);
    repeat (3) tick();

    check("scoreboard_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
